// File: rtl/pulpemu_i2c_slave.sv
// rtl/pulpemu_i2c_slave.sv - I2C target with a 16 x 8-bit register file and auto-incrementing pointer
module pulpemu_i2c_slave #(
    parameter logic [6:0] SLAVE_ADDR = 7'h50
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_oe_o,
    input  logic [3:0] host_addr_i,
    output logic [7:0] host_rdata_o,
    output logic       wr_valid_o,
    output logic [3:0] wr_addr_o,
    output logic       busy_o
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ADDR     = 3'd1;
    localparam logic [2:0] S_ADDR_ACK = 3'd2;
    localparam logic [2:0] S_WR_DATA  = 3'd3;
    localparam logic [2:0] S_WR_ACK   = 3'd4;
    localparam logic [2:0] S_RD_DATA  = 3'd5;
    localparam logic [2:0] S_RD_ACK   = 3'd6;
    localparam logic [2:0] S_WAIT     = 3'd7;

    logic scl_meta, scl_sync, scl_hist;
    logic sda_meta, sda_sync, sda_hist;

    logic [2:0]        state;
    logic [3:0]        bit_cnt;
    logic [7:0]        shreg;
    logic [3:0]        ptr;
    logic              rw;
    logic              first_byte;
    logic              ack_n;
    logic [15:0][7:0]  regs;

    logic scl_rise, scl_fall, start_det, stop_det;
    logic [3:0] ptr_inc;

    // Two-flop synchronisers plus a history stage; reset to 1 so an idle bus produces no events
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            scl_meta <= 1'b1;
            scl_sync <= 1'b1;
            scl_hist <= 1'b1;
            sda_meta <= 1'b1;
            sda_sync <= 1'b1;
            sda_hist <= 1'b1;
        end else begin
            scl_meta <= scl_i;
            scl_sync <= scl_meta;
            scl_hist <= scl_sync;
            sda_meta <= sda_i;
            sda_sync <= sda_meta;
            sda_hist <= sda_sync;
        end
    end

    assign scl_rise  = scl_sync & ~scl_hist;
    assign scl_fall  = ~scl_sync & scl_hist;
    // SDA may only move while SCL is high for START/STOP, so both SCL samples must be high
    assign start_det = scl_sync & scl_hist & sda_hist & ~sda_sync;
    assign stop_det  = scl_sync & scl_hist & ~sda_hist & sda_sync;
    assign ptr_inc   = ptr + 4'd1;

    assign host_rdata_o = regs[host_addr_i];

    // Protocol FSM: sample on SCL rise, change SDA drive only on SCL fall
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state      <= S_IDLE;
            bit_cnt    <= 4'd0;
            shreg      <= 8'h00;
            ptr        <= 4'd0;
            rw         <= 1'b0;
            first_byte <= 1'b0;
            ack_n      <= 1'b1;
            regs       <= '0;
            sda_oe_o   <= 1'b0;
            wr_valid_o <= 1'b0;
            wr_addr_o  <= 4'd0;
            busy_o     <= 1'b0;
        end else begin
            wr_valid_o <= 1'b0;
            if (start_det) begin
                state    <= S_ADDR;
                bit_cnt  <= 4'd0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b1;
            end else if (stop_det) begin
                state    <= S_IDLE;
                bit_cnt  <= 4'd0;
                sda_oe_o <= 1'b0;
                busy_o   <= 1'b0;
            end else begin
                case (state)
                    S_ADDR: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            bit_cnt <= 4'd0;
                            if (shreg[7:1] == SLAVE_ADDR) begin
                                state    <= S_ADDR_ACK;
                                sda_oe_o <= 1'b1;
                                rw       <= shreg[0];
                            end else begin
                                state    <= S_WAIT;
                                sda_oe_o <= 1'b0;
                            end
                        end
                    end
                    S_ADDR_ACK: begin
                        if (scl_fall) begin
                            bit_cnt <= 4'd0;
                            if (rw) begin
                                state    <= S_RD_DATA;
                                shreg    <= regs[ptr];
                                sda_oe_o <= ~regs[ptr][7];
                            end else begin
                                state      <= S_WR_DATA;
                                sda_oe_o   <= 1'b0;
                                first_byte <= 1'b1;
                            end
                        end
                    end
                    S_WR_DATA: begin
                        if (scl_rise) begin
                            shreg   <= {shreg[6:0], sda_sync};
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall && bit_cnt == 4'd8) begin
                            // Commit only once the whole byte is in, so an aborted byte is dropped
                            if (first_byte) begin
                                ptr        <= shreg[3:0];
                                first_byte <= 1'b0;
                            end else begin
                                regs[ptr]  <= shreg;
                                wr_valid_o <= 1'b1;
                                wr_addr_o  <= ptr;
                                ptr        <= ptr_inc;
                            end
                            bit_cnt  <= 4'd0;
                            sda_oe_o <= 1'b1;
                            state    <= S_WR_ACK;
                        end
                    end
                    S_WR_ACK: begin
                        if (scl_fall) begin
                            sda_oe_o <= 1'b0;
                            state    <= S_WR_DATA;
                        end
                    end
                    S_RD_DATA: begin
                        if (scl_rise) begin
                            bit_cnt <= bit_cnt + 4'd1;
                        end else if (scl_fall) begin
                            if (bit_cnt == 4'd8) begin
                                sda_oe_o <= 1'b0;
                                bit_cnt  <= 4'd0;
                                state    <= S_RD_ACK;
                            end else if (bit_cnt != 4'd0) begin
                                sda_oe_o <= ~shreg[6];
                                shreg    <= {shreg[6:0], 1'b0};
                            end
                        end
                    end
                    S_RD_ACK: begin
                        if (scl_rise) begin
                            ack_n <= sda_sync;
                        end else if (scl_fall) begin
                            if (!ack_n) begin
                                ptr      <= ptr_inc;
                                shreg    <= regs[ptr_inc];
                                sda_oe_o <= ~regs[ptr_inc][7];
                                bit_cnt  <= 4'd0;
                                state    <= S_RD_DATA;
                            end else begin
                                sda_oe_o <= 1'b0;
                                state    <= S_WAIT;
                            end
                        end
                    end
                    default: begin
                        // IDLE and WAIT ignore SCL activity until START or STOP
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_pulpemu_i2c_slave.sv
// tb/tb_pulpemu_i2c_slave.sv - self-checking bench for pulpemu_i2c_slave
module tb_pulpemu_i2c_slave;

    localparam int Q = 8;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       scl_m = 1'b1;
    logic       sda_m = 1'b1;
    logic [3:0] host_addr = 4'd0;
    logic       sda_oe;
    logic [7:0] host_rdata;
    logic       wr_valid;
    logic [3:0] wr_addr;
    logic       busy;
    logic       sda_line;

    int checks = 0;
    int fails  = 0;

    logic [7:0] model [16];
    logic [3:0] exp_wr [$];
    logic [7:0] exp_rd [$];

    assign sda_line = sda_m & ~sda_oe;

    pulpemu_i2c_slave #(.SLAVE_ADDR(7'h50)) dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .scl_i       (scl_m),
        .sda_i       (sda_line),
        .sda_oe_o    (sda_oe),
        .host_addr_i (host_addr),
        .host_rdata_o(host_rdata),
        .wr_valid_o  (wr_valid),
        .wr_addr_o   (wr_addr),
        .busy_o      (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #3ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Scoreboard for write commits
    always @(negedge clk) begin
        if (!rst && wr_valid) begin
            checks++;
            if (exp_wr.size() == 0) begin
                fails++;
                $display("FAIL wr_valid_unexpected: got addr %0h, none expected", wr_addr);
            end else begin
                automatic logic [3:0] e = exp_wr.pop_front();
                if (wr_addr !== e) begin
                    fails++;
                    $display("FAIL wr_addr: got %0h, expected %0h", wr_addr, e);
                end
            end
        end
    end

    task automatic wait_q();
        repeat (Q) @(negedge clk);
    endtask

    task automatic bus_start();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_rstart();
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic bus_stop();
        sda_m = 1'b0; wait_q();
        scl_m = 1'b1; wait_q();
        sda_m = 1'b1; wait_q();
    endtask

    task automatic send_bit(input logic b);
        sda_m = b;    wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic write_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        sda_m = 1'b1; wait_q();
        scl_m = 1'b1; wait_q();
        ack = sda_line;
        wait_q();
        scl_m = 1'b0; wait_q();
    endtask

    task automatic read_byte(input logic ack_bit, output logic [7:0] b);
        b = 8'h00;
        sda_m = 1'b1;
        for (int i = 0; i < 8; i++) begin
            wait_q();
            scl_m = 1'b1; wait_q();
            b = {b[6:0], sda_line};
            wait_q();
            scl_m = 1'b0;
        end
        wait_q();
        sda_m = ack_bit; wait_q();
        scl_m = 1'b1; wait_q(); wait_q();
        scl_m = 1'b0;
        sda_m = 1'b1;
        wait_q();
    endtask

    task automatic expect_write(input logic [3:0] a, input logic [7:0] d);
        exp_wr.push_back(a);
        model[a] = d;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (sda_oe !== 1'b0) begin fails++; $display("FAIL reset_sda_oe: got %b, expected 0", sda_oe); end
        checks++;
        if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %b, expected 0", busy); end
        checks++;
        if (wr_valid !== 1'b0) begin fails++; $display("FAIL reset_wr_valid: got %b, expected 0", wr_valid); end
        for (int i = 0; i < 16; i++) begin
            model[i] = 8'h00;
            host_addr = i[3:0]; #1;
            checks++;
            if (host_rdata !== 8'h00) begin
                fails++; $display("FAIL reset_reg[%0d]: got %02h, expected 00", i, host_rdata);
            end
        end
        wait_q();
    endtask

    task automatic test_write();
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_addr_ack: got %b, expected 0", ack); end
        write_byte(8'h03, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_ptr_ack: got %b, expected 0", ack); end
        expect_write(4'd3, 8'h5A);
        write_byte(8'h5A, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data0_ack: got %b, expected 0", ack); end
        expect_write(4'd4, 8'hC3);
        write_byte(8'hC3, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wr_data1_ack: got %b, expected 0", ack); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL wr_busy_mid: got %b, expected 1", busy); end
        bus_stop();
        wait_q();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL wr_busy_after_stop: got %b, expected 0", busy); end
        checks++;
        if (exp_wr.size() != 0) begin fails++; $display("FAIL wr_pulses_missing: got %0d outstanding, expected 0", exp_wr.size()); end
        for (int i = 0; i < 16; i++) begin
            host_addr = i[3:0]; #1;
            checks++;
            if (host_rdata !== model[i]) begin
                fails++; $display("FAIL wr_reg[%0d]: got %02h, expected %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_write_read();
        logic ack;
        logic [7:0] b, e;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        bus_rstart();
        write_byte(8'hA1, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL rd_addr_ack: got %b, expected 0", ack); end
        exp_rd.push_back(model[3]);
        exp_rd.push_back(model[4]);
        read_byte(1'b0, b);
        e = exp_rd.pop_front();
        checks++; if (b !== e) begin fails++; $display("FAIL rd_byte0: got %02h, expected %02h", b, e); end
        read_byte(1'b1, b);
        e = exp_rd.pop_front();
        checks++; if (b !== e) begin fails++; $display("FAIL rd_byte1: got %02h, expected %02h", b, e); end
        checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rd_nack_release: got %b, expected 0", sda_oe); end
        bus_stop();
        wait_q();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rd_busy_after_stop: got %b, expected 0", busy); end
    endtask

    task automatic test_mismatch();
        logic ack;
        bus_start();
        write_byte(8'hA2, ack);
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_addr_nack: got %b, expected 1", ack); end
        write_byte(8'h01, ack);
        write_byte(8'h55, ack);
        checks++; if (ack !== 1'b1) begin fails++; $display("FAIL mm_data_nack: got %b, expected 1", ack); end
        checks++; if (busy !== 1'b1) begin fails++; $display("FAIL mm_busy: got %b, expected 1", busy); end
        bus_stop();
        wait_q();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL mm_busy_after_stop: got %b, expected 0", busy); end
        for (int i = 0; i < 16; i++) begin
            host_addr = i[3:0]; #1;
            checks++;
            if (host_rdata !== model[i]) begin
                fails++; $display("FAIL mm_reg[%0d]: got %02h, expected %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_wrap();
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h0F, ack);
        expect_write(4'd15, 8'h11);
        write_byte(8'h11, ack);
        expect_write(4'd0, 8'h22);
        write_byte(8'h22, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL wrap_ack: got %b, expected 0", ack); end
        bus_stop();
        wait_q();
        host_addr = 4'd15; #1;
        checks++; if (host_rdata !== 8'h11) begin fails++; $display("FAIL wrap_reg15: got %02h, expected 11", host_rdata); end
        host_addr = 4'd0; #1;
        checks++; if (host_rdata !== 8'h22) begin fails++; $display("FAIL wrap_reg0: got %02h, expected 22", host_rdata); end
        checks++;
        if (exp_wr.size() != 0) begin fails++; $display("FAIL wrap_pulses_missing: got %0d outstanding, expected 0", exp_wr.size()); end
    endtask

    task automatic test_partial();
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h02, ack);
        send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b1);
        bus_stop();
        wait_q();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL partial_busy: got %b, expected 0", busy); end
        checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL partial_sda_oe: got %b, expected 0", sda_oe); end
        for (int i = 0; i < 16; i++) begin
            host_addr = i[3:0]; #1;
            checks++;
            if (host_rdata !== model[i]) begin
                fails++; $display("FAIL partial_reg[%0d]: got %02h, expected %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        checks++; if (ack !== 1'b0) begin fails++; $display("FAIL b2b_addr_ack: got %b, expected 0", ack); end
        write_byte(8'h02, ack);
        expect_write(4'd2, 8'h77);
        write_byte(8'h77, ack);
        bus_stop();
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h07, ack);
        expect_write(4'd7, 8'hE1);
        write_byte(8'hE1, ack);
        bus_stop();
        wait_q();
        host_addr = 4'd2; #1;
        checks++; if (host_rdata !== 8'h77) begin fails++; $display("FAIL b2b_reg2: got %02h, expected 77", host_rdata); end
        host_addr = 4'd7; #1;
        checks++; if (host_rdata !== 8'hE1) begin fails++; $display("FAIL b2b_reg7: got %02h, expected e1", host_rdata); end
        checks++;
        if (exp_wr.size() != 0) begin fails++; $display("FAIL b2b_pulses_missing: got %0d outstanding, expected 0", exp_wr.size()); end
    endtask

    task automatic test_reset_mid_read();
        logic ack;
        bus_start();
        write_byte(8'hA0, ack);
        write_byte(8'h03, ack);
        bus_rstart();
        write_byte(8'hA1, ack);
        // reg[3] = 0x5A, so the first data bit is 0 and the target is pulling SDA low
        checks++; if (sda_oe !== 1'b1) begin fails++; $display("FAIL rst_rd_driving: got %b, expected 1", sda_oe); end
        rst = 1'b1;
        @(negedge clk);
        checks++; if (sda_oe !== 1'b0) begin fails++; $display("FAIL rst_sda_release: got %b, expected 0", sda_oe); end
        rst = 1'b0;
        for (int i = 0; i < 16; i++) model[i] = 8'h00;
        scl_m = 1'b1;
        sda_m = 1'b1;
        wait_q();
        checks++; if (busy !== 1'b0) begin fails++; $display("FAIL rst_busy: got %b, expected 0", busy); end
        for (int i = 0; i < 16; i++) begin
            host_addr = i[3:0]; #1;
            checks++;
            if (host_rdata !== model[i]) begin
                fails++; $display("FAIL rst_reg[%0d]: got %02h, expected %02h", i, host_rdata, model[i]);
            end
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_write_read();
        test_mismatch();
        test_wrap();
        test_partial();
        test_back_to_back();
        test_reset_mid_read();
        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
